// File: rtl/pipe_pkg.sv
// Shared default widths and payload layout for the ID/EX pipeline boundary.
package pipe_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int EX_W   = 4;
    localparam int MEM_W  = 3;
    localparam int WB_W   = 2;

    typedef struct packed {
        logic [EX_W-1:0]   ex;
        logic [MEM_W-1:0]  mem;
        logic [WB_W-1:0]   wb;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
    } id_ex_payload_t;

endpackage

// File: rtl/pipe_payload_reg.sv
// One storage slot: enable-loaded payload register plus valid bit.
// reset zeroes everything; flush only drops the valid bit.
module pipe_payload_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         load,
    input  logic         valid_d,
    input  logic [W-1:0] data_d,
    output logic         valid,
    output logic [W-1:0] data
);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            valid <= flush ? 1'b0 : valid_d;
            if (load) begin
                data <= data_d;
            end
        end
    end

endmodule

// File: rtl/id_ex_elastic.sv
// ID/EX pipeline register with a two-entry skid buffer, flush and a
// saturating stall counter; in_ready is fully registered.
module id_ex_elastic #(
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int REG_W  = pipe_pkg::REG_W,
    parameter int EX_W   = pipe_pkg::EX_W,
    parameter int MEM_W  = pipe_pkg::MEM_W,
    parameter int WB_W   = pipe_pkg::WB_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [EX_W-1:0]   EX_D,
    input  logic [MEM_W-1:0]  MEM_D,
    input  logic [WB_W-1:0]   WB_D,
    input  logic [REG_W-1:0]  Rs_D,
    input  logic [REG_W-1:0]  Rt_D,
    input  logic [REG_W-1:0]  Rd_D,
    input  logic [DATA_W-1:0] RD1_D,
    input  logic [DATA_W-1:0] RD2_D,
    input  logic [DATA_W-1:0] SignImm_D,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [EX_W-1:0]   EX_E,
    output logic [MEM_W-1:0]  MEM_E,
    output logic [WB_W-1:0]   WB_E,
    output logic [REG_W-1:0]  Rs_E,
    output logic [REG_W-1:0]  Rt_E,
    output logic [REG_W-1:0]  Rd_E,
    output logic [DATA_W-1:0] RD1_E,
    output logic [DATA_W-1:0] RD2_E,
    output logic [DATA_W-1:0] SignImm_E,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int PW = EX_W + MEM_W + WB_W + 3 * REG_W + 3 * DATA_W;

    logic [PW-1:0] in_flat;
    logic [PW-1:0] main_data;
    logic [PW-1:0] skid_data;
    logic [PW-1:0] main_src;
    logic          main_valid;
    logic          skid_valid;
    logic          main_valid_d;
    logic          skid_valid_d;
    logic          main_load;
    logic          skid_load;
    logic          take;
    logic          drain;

    logic [EX_W-1:0]  ex_q;
    logic [MEM_W-1:0] mem_q;
    logic [WB_W-1:0]  wb_q;

    assign in_flat = {EX_D, MEM_D, WB_D, Rs_D, Rt_D, Rd_D, RD1_D, RD2_D, SignImm_D};

    assign take  = in_valid && in_ready;
    assign drain = main_valid && out_ready;

    // Skid promotes into main on a drain; a fresh input only lands in main
    // when main is empty or draining with nothing waiting in skid.
    always_comb begin
        main_load    = 1'b0;
        skid_load    = 1'b0;
        main_src     = in_flat;
        main_valid_d = main_valid;
        skid_valid_d = skid_valid;
        if (drain) begin
            if (skid_valid) begin
                main_load    = 1'b1;
                main_src     = skid_data;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (take) begin
                main_load    = 1'b1;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (take) begin
            if (main_valid) begin
                skid_load    = 1'b1;
                skid_valid_d = 1'b1;
            end else begin
                main_load    = 1'b1;
                main_valid_d = 1'b1;
            end
        end
        if (flush) begin
            main_load = 1'b0;
            skid_load = 1'b0;
        end
    end

    pipe_payload_reg #(.W(PW)) u_main (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .load    (main_load),
        .valid_d (main_valid_d),
        .data_d  (main_src),
        .valid   (main_valid),
        .data    (main_data)
    );

    pipe_payload_reg #(.W(PW)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .load    (skid_load),
        .valid_d (skid_valid_d),
        .data_d  (in_flat),
        .valid   (skid_valid),
        .data    (skid_data)
    );

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            in_ready <= 1'b1;
        end else begin
            in_ready <= !skid_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (main_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign {ex_q, mem_q, wb_q, Rs_E, Rt_E, Rd_E, RD1_E, RD2_E, SignImm_E} = main_data;

    assign out_valid = main_valid;
    assign EX_E      = main_valid ? ex_q  : '0;
    assign MEM_E     = main_valid ? mem_q : '0;
    assign WB_E      = main_valid ? wb_q  : '0;

endmodule

// File: tb/tb_id_ex_elastic.sv
// Directed and random checks of id_ex_elastic against a queue scoreboard.
module tb_id_ex_elastic;
    import pipe_pkg::*;

    logic clk = 1'b0;
    logic reset, flush, in_valid, out_ready;
    logic in_ready, out_valid, in_ready2, out_valid2;
    logic [15:0] stall_cnt;
    logic [1:0]  stall_cnt2;
    id_ex_payload_t din, dout, dout2;
    id_ex_payload_t q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_elastic dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .EX_D(din.ex), .MEM_D(din.mem), .WB_D(din.wb), .Rs_D(din.rs), .Rt_D(din.rt), .Rd_D(din.rd),
        .RD1_D(din.rd1), .RD2_D(din.rd2), .SignImm_D(din.imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .EX_E(dout.ex), .MEM_E(dout.mem), .WB_E(dout.wb), .Rs_E(dout.rs), .Rt_E(dout.rt), .Rd_E(dout.rd),
        .RD1_E(dout.rd1), .RD2_E(dout.rd2), .SignImm_E(dout.imm), .stall_cnt(stall_cnt)
    );

    id_ex_elastic #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
        .EX_D(din.ex), .MEM_D(din.mem), .WB_D(din.wb), .Rs_D(din.rs), .Rt_D(din.rt), .Rd_D(din.rd),
        .RD1_D(din.rd1), .RD2_D(din.rd2), .SignImm_D(din.imm),
        .out_valid(out_valid2), .out_ready(out_ready),
        .EX_E(dout2.ex), .MEM_E(dout2.mem), .WB_E(dout2.wb), .Rs_E(dout2.rs), .Rt_E(dout2.rt), .Rd_E(dout2.rd),
        .RD1_E(dout2.rd1), .RD2_E(dout2.rd2), .SignImm_E(dout2.imm), .stall_cnt(stall_cnt2)
    );

    function automatic id_ex_payload_t mk(input logic [31:0] v);
        id_ex_payload_t p;
        p.ex  = 4'(v) | 4'h1;
        p.mem = 3'(v) | 3'h1;
        p.wb  = 2'(v) | 2'h1;
        p.rs  = 5'(v);
        p.rt  = 5'(v + 1);
        p.rd  = 5'(v + 2);
        p.rd1 = v;
        p.rd2 = ~v;
        p.imm = v * 3;
        return p;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard update for the edge about to happen, then advance one cycle.
    task automatic cycle();
        logic acc, drn;
        acc = in_valid && in_ready && !flush && !reset;
        drn = out_valid && out_ready && !flush && !reset;
        if (drn) begin
            chk("drain_has_entry", 128'(q.size() != 0), 128'(1));
            if (q.size() != 0) begin
                chk("drain_payload", 128'(dout), 128'(q[0]));
                void'(q.pop_front());
            end
        end
        if (flush || reset) q.delete();
        if (acc) q.push_back(din);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_out_valid"}, 128'(out_valid), 128'(q.size() != 0));
        chk({tag, "_in_ready"}, 128'(in_ready), 128'(q.size() < 2));
        if (!out_valid) chk({tag, "_bubble_ctrl"}, 128'({dout.ex, dout.mem, dout.wb}), 128'(0));
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din = mk(32'h0);
        @(posedge clk); #1;
        cycle();
        cycle();
        reset = 1'b0;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_payload", 128'(dout), 128'(0));
        chk("rst_stall_cnt", 128'(stall_cnt), 128'(0));

        // single transfer, 1-cycle latency
        in_valid = 1'b1; din = mk(32'h1234); out_ready = 1'b1;
        cycle();
        chk("lat_out_valid", 128'(out_valid), 128'(1));
        chk("lat_rd1", 128'(dout.rd1), 128'(32'h1234));
        chk("lat_in_ready", 128'(in_ready), 128'(1));
        in_valid = 1'b0;
        cycle();
        chk_model("lat_drained");

        // skid fill and ordered drain
        out_ready = 1'b0; in_valid = 1'b1; din = mk(32'hA);
        cycle();
        din = mk(32'hB);
        cycle();
        chk("skid_in_ready_full", 128'(in_ready), 128'(0));
        chk("skid_head_a", 128'(dout.rd1), 128'(32'hA));
        in_valid = 1'b0; out_ready = 1'b1;
        cycle();
        chk("skid_head_b", 128'(dout.rd1), 128'(32'hB));
        chk("skid_in_ready_after_a", 128'(in_ready), 128'(1));
        cycle();
        chk_model("skid_empty");
        chk("skid_data_hold", 128'(dout.rd1), 128'(32'hB));

        // flush with both slots full and a payload offered
        out_ready = 1'b0; in_valid = 1'b1; din = mk(32'h21);
        cycle();
        din = mk(32'h22);
        cycle();
        chk("flush_pre_full", 128'(in_ready), 128'(0));
        flush = 1'b1; din = mk(32'hC);
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", 128'(out_valid), 128'(0));
        chk("flush_ctrl_zero", 128'({dout.ex, dout.mem, dout.wb}), 128'(0));
        chk("flush_in_ready", 128'(in_ready), 128'(1));
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("flush_no_0xc", 128'(out_valid), 128'(0));
        end

        // stall counter and saturation of the narrow instance
        reset = 1'b1;
        cycle();
        reset = 1'b0; out_ready = 1'b0; in_valid = 1'b1; din = mk(32'h31);
        cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        chk("stall_cnt_5", 128'(stall_cnt), 128'(5));
        cycle();
        chk("stall_cnt_6", 128'(stall_cnt), 128'(6));
        chk("stall_cnt_sat", 128'(stall_cnt2), 128'(3));

        // reset while full
        in_valid = 1'b1; din = mk(32'hF);
        cycle();
        chk("rst_full_pre", 128'(in_ready), 128'(0));
        in_valid = 1'b0; reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("rst_full_out_valid", 128'(out_valid), 128'(0));
        chk("rst_full_payload", 128'(dout), 128'(0));
        chk("rst_full_stall", 128'(stall_cnt), 128'(0));
        chk("rst_full_in_ready", 128'(in_ready), 128'(1));
        chk("rst_full_narrow", 128'({dout2, stall_cnt2, out_valid2, in_ready2}), 128'(1));
        in_valid = 1'b1; out_ready = 1'b1; din = mk(32'h55);
        cycle();
        chk("post_rst_accept", 128'(dout.rd1), 128'(32'h55));
        chk_model("post_rst");

        // random traffic with occasional flushes
        for (int i = 0; i < 10000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 49) == 0);
            din       = mk($urandom);
            cycle();
            chk_model("rand");
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        chk("final_sb_empty", 128'(q.size()), 128'(0));
        chk("final_out_valid", 128'(out_valid), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_elastic.md
ID_EX_ELASTIC -- requirements
Module: id_ex_elastic

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of RD1/RD2/SignImm payload fields.
REQ-002 SHALL have parameter REG_W, default 5, width of Rs/Rt/Rd register specifiers.
REQ-003 SHALL have parameters EX_W, MEM_W, WB_W, defaults 4, 3, 2, widths of EX, MEM and WB control groups.
REQ-004 SHALL have parameter CNT_W, default 16, width of stall counter.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-007 flush  in  1  discard all held entries (branch/hazard squash).
REQ-008 in_valid  in  1  ID stage presents a valid payload.
REQ-009 in_ready  out  1  stage can accept a payload this cycle.
REQ-010 EX_D/MEM_D/WB_D  in  EX_W/MEM_W/WB_W  control groups from ID.
REQ-011 Rs_D/Rt_D/Rd_D  in  REG_W each  register specifiers from ID.
REQ-012 RD1_D/RD2_D/SignImm_D  in  DATA_W each  operand and immediate from ID.
REQ-013 out_valid  out  1  EX-side payload valid.
REQ-014 out_ready  in  1  EX stage consumes payload this cycle.
REQ-015 EX_E/MEM_E/WB_E, Rs_E/Rt_E/Rd_E, RD1_E/RD2_E/SignImm_E  out  same widths  registered payload to EX.
REQ-016 stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

Function
REQ-017 Two storage slots SHALL exist: main (drives outputs) and skid; each with a valid bit.
REQ-018 Transfer in SHALL occur when in_valid&&in_ready; transfer out when out_valid&&out_ready.
REQ-019 in_ready SHALL be registered and equal !skid_valid (no combinational path from out_ready).
REQ-020 Latency SHALL be 1 cycle: payload accepted at edge N appears on outputs after edge N when main is empty or draining.
REQ-021 Input accepted while main full and not draining SHALL go to skid; skid SHALL move to main on the next drain edge, preserving order.
REQ-022 Simultaneous accept and drain with skid empty SHALL load main directly; skid stays empty.
REQ-023 Full condition (both valid) SHALL deassert in_ready; no payload SHALL be dropped or duplicated.
REQ-024 out_valid SHALL equal main valid bit.
REQ-025 When out_valid=0, EX_E, MEM_E, WB_E SHALL read zero (bubble = NOP); data/specifier outputs SHALL hold last value.
REQ-026 flush SHALL clear both valid bits at that edge; payload offered in the flush cycle SHALL be discarded; in_ready=1 next cycle.
REQ-027 flush SHALL take priority over accept and drain; reset SHALL take priority over flush.
REQ-028 stall_cnt SHALL increment by 1 per stall cycle, hold at all-ones, clear only on reset.
REQ-029 Payload outputs SHALL change only on accepted transfers, skid promotion, or reset.

Reset
REQ-030 On reset: both valid bits 0, in_ready 1, out_valid 0, all payload outputs 0, stall_cnt 0.
REQ-031 Reset asserted mid-stall SHALL discard both slots; first post-reset accept behaves as empty pipeline.

Structure
REQ-032 Shared package pipe_pkg SHALL hold default widths (DATA_W, REG_W, EX_W, MEM_W, WB_W) and the packed payload struct type id_ex_payload_t.
REQ-033 One sub-module, pipe_payload_reg (parametrised enable-loaded register with valid bit and synchronous clear), SHALL be instantiated for main and skid slots.

Verification
REQ-034 Reset then in_valid=1, RD1_D=0x1234, out_ready=1 -> next cycle out_valid=1, RD1_E=0x1234, in_ready=1.
REQ-035 out_ready=0, send A=0xA then B=0xB -> in_ready=0 after B; out_ready=1 -> A then B on consecutive cycles, in_ready=1 after A drains.
REQ-036 Both slots full, flush=1 with in_valid=1 payload 0xC -> next cycle out_valid=0, EX_E/MEM_E/WB_E=0, in_ready=1, 0xC never appears.
REQ-037 out_valid=1, out_ready=0 for 5 cycles -> stall_cnt=5; with CNT_W=2 forced, 6 stalls -> stall_cnt=3.
REQ-038 Reset during full stall with EX_D=0xF -> all outputs 0, stall_cnt=0, in_ready=1 next cycle.
REQ-039 Random in_valid/out_ready 10k cycles -> output sequence equals accepted-input sequence minus flushed entries, no loss or duplication.
